// File: rtl/button_hold_repeat.sv
// Button hold/auto-repeat generator: emits press, repeat, long_press and release
// pulses plus a held level, all timed from a millisecond prescaler.
module button_hold_repeat #(
  parameter int unsigned CLK_PER_MS = 100000,
  parameter int unsigned HOLD_MS    = 500,
  parameter int unsigned REPEAT_MS  = 100,
  parameter int unsigned LONG_MS    = 2000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_level_i,
  output logic press_o,
  output logic repeat_o,
  output logic long_press_o,
  output logic release_o,
  output logic held_o
);

  localparam int unsigned PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_PER_MS - 1);
  localparam logic [15:0]   HOLD_LAST  = 16'(HOLD_MS - 1);
  localparam logic [15:0]   REP_LAST   = 16'(REPEAT_MS - 1);
  localparam logic [15:0]   LONG_LAST  = 16'(LONG_MS - 1);
  localparam bit            LONG_EN    = (LONG_MS != 0);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PRESSED   = 2'd1;
  localparam logic [1:0] ST_REPEATING = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          btn_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   ms_cnt_q, ms_cnt_d;
  logic [15:0]   rep_cnt_q, rep_cnt_d;
  logic          long_done_q, long_done_d;
  logic          press_q, press_d;
  logic          repeat_q, repeat_d;
  logic          long_q, long_d;
  logic          release_q, release_d;
  logic          held_q, held_d;
  logic          rise_s, fall_s, tick_s;

  assign rise_s = btn_level_i & ~btn_q;
  assign fall_s = ~btn_level_i & btn_q;
  assign tick_s = (state_q != ST_IDLE) && (presc_q == PRESC_MAX);

  // Next-state logic; a fall always takes priority over a coincident tick.
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    ms_cnt_d    = ms_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    long_done_d = long_done_q;
    press_d     = 1'b0;
    repeat_d    = 1'b0;
    long_d      = 1'b0;
    release_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise_s) begin
          state_d     = ST_PRESSED;
          press_d     = 1'b1;
          presc_d     = '0;
          ms_cnt_d    = 16'd0;
          rep_cnt_d   = 16'd0;
          long_done_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRESSED, ST_REPEATING: begin
        if (fall_s) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          presc_d   = '0;
          ms_cnt_d  = 16'd0;
          rep_cnt_d = 16'd0;
        end else if (tick_s) begin
          presc_d  = '0;
          ms_cnt_d = (ms_cnt_q == 16'hFFFF) ? ms_cnt_q : ms_cnt_q + 16'd1;
          if (LONG_EN && (ms_cnt_q == LONG_LAST) && !long_done_q) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
          end else begin
            long_done_d = long_done_q;
          end
          if (state_q == ST_PRESSED) begin
            if (ms_cnt_q == HOLD_LAST) begin
              state_d   = ST_REPEATING;
              repeat_d  = 1'b1;
              rep_cnt_d = 16'd0;
            end else begin
              state_d = ST_PRESSED;
            end
          end else begin
            if (rep_cnt_q == REP_LAST) begin
              repeat_d  = 1'b1;
              rep_cnt_d = 16'd0;
            end else begin
              rep_cnt_d = rep_cnt_q + 16'd1;
            end
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        presc_d     = '0;
        ms_cnt_d    = 16'd0;
        rep_cnt_d   = 16'd0;
        long_done_d = 1'b0;
      end
    endcase
    held_d = (state_d != ST_IDLE);
  end

  // State and output registers; btn_q resets high so a held button needs a fresh rise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      btn_q       <= 1'b1;
      presc_q     <= '0;
      ms_cnt_q    <= 16'd0;
      rep_cnt_q   <= 16'd0;
      long_done_q <= 1'b0;
      press_q     <= 1'b0;
      repeat_q    <= 1'b0;
      long_q      <= 1'b0;
      release_q   <= 1'b0;
      held_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      btn_q       <= btn_level_i;
      presc_q     <= presc_d;
      ms_cnt_q    <= ms_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      long_done_q <= long_done_d;
      press_q     <= press_d;
      repeat_q    <= repeat_d;
      long_q      <= long_d;
      release_q   <= release_d;
      held_q      <= held_d;
    end
  end

  assign press_o      = press_q;
  assign repeat_o     = repeat_q;
  assign long_press_o = long_q;
  assign release_o    = release_q;
  assign held_o       = held_q;

endmodule

// File: tb/tb_button_hold_repeat.sv
// Directed bench for button_hold_repeat: each scenario records per-cycle output
// bitmasks (bit k = cycle N+k) and compares them against hand-derived masks.
module tb_button_hold_repeat;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic press_a, repeat_a, long_a, release_a, held_a;
  logic press_b, repeat_b, long_b, release_b, held_b;

  int n_total = 0;
  int n_bad   = 0;

  logic [63:0] m_pr, m_rp, m_lp, m_rl, m_hd, m_rp2, m_lp2;

  always #5 clk = ~clk;

  button_hold_repeat #(.CLK_PER_MS(4), .HOLD_MS(3), .REPEAT_MS(2), .LONG_MS(6)) u_dut (
    .clk_i(clk), .rst_i(rst), .btn_level_i(btn),
    .press_o(press_a), .repeat_o(repeat_a), .long_press_o(long_a),
    .release_o(release_a), .held_o(held_a)
  );

  button_hold_repeat #(.CLK_PER_MS(4), .HOLD_MS(3), .REPEAT_MS(2), .LONG_MS(0)) u_dut_nolong (
    .clk_i(clk), .rst_i(rst), .btn_level_i(btn),
    .press_o(press_b), .repeat_o(repeat_b), .long_press_o(long_b),
    .release_o(release_b), .held_o(held_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] span(input int lo, input int hi);
    logic [63:0] m;
    m = 64'd0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] bits(input int a, input int b, input int c, input int d);
    logic [63:0] m;
    m = 64'd0;
    if (a >= 0) m[a] = 1'b1;
    if (b >= 0) m[b] = 1'b1;
    if (c >= 0) m[c] = 1'b1;
    if (d >= 0) m[d] = 1'b1;
    return m;
  endfunction

  // Called just after a rising edge; drives btn from pat and rst at rst_at.
  task automatic run_scn(input logic [63:0] pat, input int total, input int rst_at);
    m_pr = 64'd0; m_rp = 64'd0; m_lp = 64'd0; m_rl = 64'd0; m_hd = 64'd0;
    m_rp2 = 64'd0; m_lp2 = 64'd0;
    for (int k = 0; k < total; k++) begin
      btn = pat[k];
      rst = (k == rst_at);
      @(negedge clk);
      m_pr[k] = press_a;   m_rp[k] = repeat_a; m_lp[k] = long_a;
      m_rl[k] = release_a; m_hd[k] = held_a;
      m_rp2[k] = repeat_b; m_lp2[k] = long_b;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    btn = 1'b0;
  endtask

  task automatic idle(input int n);
    btn = 1'b0;
    rst = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1'b1;
    btn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {59'd0, press_a, repeat_a, long_a, release_a, held_a}, 64'd0);
    @(posedge clk); #1;
    idle(3);

    // 40-cycle hold
    run_scn(span(0, 39), 44, -1);
    check("hold_press",   m_pr,  bits(1, -1, -1, -1));
    check("hold_repeat",  m_rp,  bits(13, 21, 29, 37));
    check("hold_long",    m_lp,  bits(25, -1, -1, -1));
    check("hold_release", m_rl,  bits(41, -1, -1, -1));
    check("hold_held",    m_hd,  span(1, 40));
    check("nolong_long",  m_lp2, 64'd0);
    check("nolong_rep",   m_rp2, bits(13, 21, 29, 37));
    idle(3);

    // short press
    run_scn(span(0, 4), 10, -1);
    check("short_press",   m_pr, bits(1, -1, -1, -1));
    check("short_release", m_rl, bits(6, -1, -1, -1));
    check("short_rep_long", m_rp | m_lp, 64'd0);
    check("short_held",    m_hd, span(1, 5));
    idle(3);

    // fall coincides with the tick that would have issued the first repeat
    run_scn(span(0, 11), 16, -1);
    check("tickfall_release", m_rl, bits(13, -1, -1, -1));
    check("tickfall_repeat",  m_rp, 64'd0);
    check("tickfall_held",    m_hd, span(1, 12));
    idle(3);

    // new press right after a release
    run_scn(span(0, 4) | span(7, 9), 14, -1);
    check("again_press",   m_pr, bits(1, 8, -1, -1));
    check("again_release", m_rl, bits(6, 11, -1, -1));
    check("again_held",    m_hd, span(1, 5) | span(8, 10));
    idle(3);

    // button held through reset deassertion
    btn = 1'b1;
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    run_scn(span(0, 9), 12, -1);
    check("thru_rst_quiet", m_pr | m_rp | m_lp | m_rl | m_hd, 64'd0);
    run_scn(span(0, 4), 8, -1);
    check("thru_rst_press", m_pr, bits(1, -1, -1, -1));
    idle(3);

    // reset mid-repeat, then a fresh press
    run_scn(span(0, 39), 24, 18);
    check("rst_mid_repeat",  m_rp, bits(13, -1, -1, -1));
    check("rst_mid_release", m_rl, 64'd0);
    check("rst_mid_held",    m_hd, span(1, 18));
    check("rst_mid_quiet",   (m_pr | m_rp | m_lp | m_rl | m_hd) & span(19, 23), 64'd0);
    idle(3);
    run_scn(span(0, 15), 20, -1);
    check("fresh_press",  m_pr, bits(1, -1, -1, -1));
    check("fresh_repeat", m_rp, bits(13, -1, -1, -1));
    check("fresh_release", m_rl, bits(17, -1, -1, -1));
    check("fresh_long",   m_lp, 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
